// File: rtl/irq_pending_capture.sv
// Latches rising edges on four request lines as pending events and serves them one at a
// time, highest index first, as a 2-bit code with a valid/ack handshake.
// Define IRQ_SYNC2_EN to pass req through a 2-flop synchronizer when it is asynchronous to clk.
module irq_pending_capture #(
    parameter int N  = 4,
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          ack,
    output logic [CW-1:0] code,
    output logic          valid,
    output logic [N-1:0]  pending,
    output logic [N-1:0]  overrun
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  req_s;
    logic [N-1:0]  req_q;
    logic [N-1:0]  rise;
    logic [N-1:0]  clr;
    logic [N-1:0]  pending_next;
    logic [N-1:0]  overrun_next;
    logic [CW-1:0] code_next;
    logic [CW-1:0] top_idx;

`ifdef IRQ_SYNC2_EN
    logic [N-1:0] sync1;
    logic [N-1:0] sync2;

    // Synchronizer resets high so lines already asserted at reset release raise no event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= req;
            sync2 <= sync1;
        end
    end

    assign req_s = sync2;
`else
    assign req_s = req;
`endif

    assign rise  = req_s & ~req_q;
    assign valid = (state == PRESENT);

    // Ascending scan: the last hit, i.e. the highest set bit, wins.
    always_comb begin
        top_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pending[i]) top_idx = CW'(i);
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        code_next  = code;
        clr        = '0;
        case (state)
            IDLE: begin
                if (|pending) begin
                    state_next = PRESENT;
                    code_next  = top_idx;
                end
            end
            PRESENT: begin
                if (ack) begin
                    state_next = IDLE;
                    clr[code]  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        // Set is applied after clear so a coincident new edge survives retirement.
        pending_next = (pending & ~clr) | rise;
        overrun_next = (overrun | (rise & pending)) & ~clr;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            code    <= '0;
            pending <= '0;
            overrun <= '0;
            req_q   <= '1;
        end else begin
            state   <= state_next;
            code    <= code_next;
            pending <= pending_next;
            overrun <= overrun_next;
            req_q   <= req_s;
        end
    end

endmodule
